// File: rtl/piso_ser_tx_pkg.sv
// rtl/piso_ser_tx_pkg.sv - shared types and constants for the serial transmitter
package piso_ser_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Counter width; never below one bit so WIDTH=2 still has a usable counter.
    function automatic int cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_ser_tx_if.sv
// rtl/piso_ser_tx_if.sv - word handshake and serial output bundle
interface piso_ser_tx_if
    import piso_ser_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sframe;
    logic             busy;

    modport master (
        output din, din_valid,
        input  din_ready, sout, sframe, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, sout, sframe, busy
    );
endinterface

// File: rtl/piso_ser_tx_shift_reg.sv
// rtl/piso_ser_tx_shift_reg.sv - loadable shift register with zero fill
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // Zero fill drains the register, so sout returns to 0 once a word completes.
    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = din;
        end else if (shift) begin
            shreg_d = (LSB_FIRST != 0) ? {1'b0, shreg_q[WIDTH-1:1]}
                                       : {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign sout = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[WIDTH-1];

endmodule

// File: rtl/piso_ser_tx.sv
// rtl/piso_ser_tx.sv - parallel-in/serial-out transmitter, one bit per clk
module piso_ser_tx
    import piso_ser_tx_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int LSB_FIRST = 0
) (
    input  logic         clk,
    input  logic         rst,
    piso_ser_tx_if.slave bus
);
    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             last_bit;
    logic             accept;
    logic             load;
    logic             shift;
    logic             din_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (accept) begin
                    cnt_d = '0;
                end else if (last_bit) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Ready on the final bit lets a new word follow with no idle gap.
    always_comb begin
        last_bit  = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
        din_ready = (state_q == ST_IDLE) || last_bit;
        accept    = bus.din_valid && din_ready;
        load      = accept;
        shift     = (state_q == ST_SHIFT) && !accept;
    end

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (bus.din),
        .sout  (bus.sout)
    );

    assign bus.din_ready = din_ready;
    assign bus.sframe    = (state_q == ST_SHIFT);
    assign bus.busy      = (state_q == ST_SHIFT);

endmodule
